ucie_debug_trace_capture: RTL and testbench

//  Device-side writer for the debug trace channel. Owns the free-running debug timestamp
//  and a circular trace RAM of {timestamp, event vector} entries. Arms on debug_capture_enable,

---
 rtl/ucie_debug_trace_capture_if.sv | 42 ++++
 rtl/ucie_debug_trace_capture.sv | 123 ++++++++++++
 tb/tb_ucie_debug_trace_capture.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ucie_debug_trace_capture_if.sv
// Debug trace channel bundle between the trace controller and the capture block.
//   master : controller side; drives capture control, event vector and read requests.
//   slave  : capture block; returns read data, timestamp, pointer and capture status.
// Read handshake: rd_en/rd_addr are sampled on a clock edge. rd_valid pulses for exactly
// one cycle on the following edge, together with rd_data. There is no back-pressure, and
// reads may be issued back to back.
interface ucie_debug_trace_capture_if #(
  parameter int DEPTH   = 256,
  parameter int EVENT_W = 32,
  parameter int TS_W    = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                    debug_capture_enable;
  logic [EVENT_W-1:0]      debug_trigger_mask;
  logic [EVENT_W-1:0]      event_vec;
  logic [ADDR_W-1:0]       post_trigger_count;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [TS_W+EVENT_W-1:0] rd_data;
  logic                    rd_valid;
  logic [TS_W-1:0]         debug_timestamp;
  logic [ADDR_W-1:0]       debug_trace_ptr;
  logic                    trace_wrapped;
  logic [ADDR_W-1:0]       trigger_index;
  logic [1:0]              capture_state;
  logic                    capture_done;

  modport master (
    output debug_capture_enable, debug_trigger_mask, event_vec, post_trigger_count,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, debug_timestamp, debug_trace_ptr, trace_wrapped,
    input  trigger_index, capture_state, capture_done
  );

  modport slave (
    input  debug_capture_enable, debug_trigger_mask, event_vec, post_trigger_count,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, debug_timestamp, debug_trace_ptr, trace_wrapped,
    output trigger_index, capture_state, capture_done
  );
endinterface

// File: rtl/ucie_debug_trace_capture.sv
// Device-side writer for the debug trace channel.
// It keeps a free-running timestamp and a circular trace RAM. Each entry is
// {timestamp, event vector}. Capture arms when debug_capture_enable is high. It triggers
// on the first stored event that hits debug_trigger_mask, then stops after
// post_trigger_count further stored entries.
// Ports:
//   clk, resetn : core clock; asynchronous active-low reset.
//   dbg (slave) : capture control and events in, registered read port, and status out:
//                 debug_timestamp, debug_trace_ptr, trace_wrapped, trigger_index,
//                 capture_state (0 IDLE, 1 ARMED, 2 POST, 3 DONE) and capture_done.
module ucie_debug_trace_capture #(
  parameter int DEPTH   = 256,
  parameter int EVENT_W = 32,
  parameter int TS_W    = 32
) (
  input logic                      clk,
  input logic                      resetn,
  ucie_debug_trace_capture_if.slave dbg
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = TS_W + EVENT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [TS_W-1:0]     ts;
  logic [ADDR_W-1:0]   ptr;
  logic                wrapped;
  logic [ADDR_W-1:0]   trig_idx;
  logic [ADDR_W-1:0]   remain;
  logic                wr_en;
  logic                trig_hit;
  logic [ENTRY_W-1:0]  mem [DEPTH];

  // A write needs the enable still high. Dropping the enable suppresses the write
  // in that same cycle, even while in ARMED/POST.
  always_comb begin
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    wr_en    = dbg.debug_capture_enable &&
               ((state == ST_ARMED) || (state == ST_POST)) &&
               (dbg.event_vec != '0);
    trig_hit = (dbg.event_vec & dbg.debug_trigger_mask) != '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (dbg.debug_capture_enable) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (wr_en && trig_hit) begin
          state_nxt = (dbg.post_trigger_count == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST:  if (wr_en && (remain == ADDR_W'(1))) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    // Dropping the enable aborts from any state.
    if (!dbg.debug_capture_enable) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts       <= '0;
      ptr      <= '0;
      wrapped  <= 1'b0;
      trig_idx <= '0;
      remain   <= '0;
    end else begin
      ts <= ts + 1'b1;
      // Arming clears the pointer bookkeeping. No write is possible in this cycle.
      if ((state == ST_IDLE) && dbg.debug_capture_enable) begin
        ptr      <= '0;
        wrapped  <= 1'b0;
        trig_idx <= '0;
      end
      if (wr_en) begin
        ptr <= ptr + 1'b1;
        // DEPTH is a power of two, so an all-ones pointer is the last slot.
        if (&ptr) wrapped <= 1'b1;
        if ((state == ST_ARMED) && trig_hit) begin
          trig_idx <= ptr;
          remain   <= dbg.post_trigger_count;
        end else if (state == ST_POST) begin
          remain <= remain - 1'b1;
        end
      end
    end
  end

  // The trace RAM is not reset. A read of the slot being written returns the old entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= {ts, dbg.event_vec};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dbg.rd_data  <= '0;
      dbg.rd_valid <= 1'b0;
    end else begin
      dbg.rd_valid <= dbg.rd_en;
      if (dbg.rd_en) dbg.rd_data <= mem[dbg.rd_addr];
    end
  end

  assign dbg.debug_timestamp = ts;
  assign dbg.debug_trace_ptr = ptr;
  assign dbg.trace_wrapped   = wrapped;
  assign dbg.trigger_index   = trig_idx;
  assign dbg.capture_state   = state;
  assign dbg.capture_done    = (state == ST_DONE);
endmodule

// File: tb/tb_ucie_debug_trace_capture.sv
// Bench for ucie_debug_trace_capture.
// The reference model tracks capture as a count of stored events since arm. It also keeps
// a trigger position, and an array image of the trace RAM. Expected read data is queued
// when a read is issued, and a monitor compares it when rd_valid pulses. A second, narrow
// instance (TS_W=8) checks that the timestamp wraps.
module tb_ucie_debug_trace_capture;
  localparam int DEPTH = 256;
  localparam int EW    = 32;
  localparam int TSW   = 32;
  localparam int AW    = 8;
  localparam int W     = TSW + EW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ucie_debug_trace_capture_if #(.DEPTH(DEPTH), .EVENT_W(EW), .TS_W(TSW)) dif ();
  ucie_debug_trace_capture_if #(.DEPTH(4), .EVENT_W(8), .TS_W(8)) sif ();

  ucie_debug_trace_capture #(.DEPTH(DEPTH), .EVENT_W(EW), .TS_W(TSW)) dut (
    .clk(clk), .resetn(resetn), .dbg(dif)
  );
  ucie_debug_trace_capture #(.DEPTH(4), .EVENT_W(8), .TS_W(8)) dut_small (
    .clk(clk), .resetn(resetn), .dbg(sif)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int unsigned      cyc = 0;          // clock edges since reset release
  logic [W-1:0]     exp_q[$];
  bit               known_q[$];
  logic [W-1:0]     m_mem [DEPTH];
  bit               m_known [DEPTH];
  bit               armed = 0, triggered = 0, done_m = 0;
  int               stored = 0, trig_no = 0, trig_post = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [63:0] e_state;
    e_state = !armed ? 64'd0 : done_m ? 64'd3 : triggered ? 64'd2 : 64'd1;
    chk({tag, " ts"}, 64'(dif.debug_timestamp), 64'(cyc));
    chk({tag, " ptr"}, 64'(dif.debug_trace_ptr), 64'(stored % DEPTH));
    chk({tag, " wrapped"}, 64'(dif.trace_wrapped), 64'(stored >= DEPTH));
    chk({tag, " trig_idx"}, 64'(dif.trigger_index), 64'(trig_no % DEPTH));
    chk({tag, " state"}, 64'(dif.capture_state), e_state);
    chk({tag, " done"}, 64'(dif.capture_done), 64'(e_state == 64'd3));
    chk({tag, " small ts"}, 64'(sif.debug_timestamp), 64'(cyc % 256));
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of stimulus, predicts its effect, then steps past the clock edge.
  task automatic cycle(input bit en, input logic [EW-1:0] mask, input logic [EW-1:0] ev,
                       input logic [AW-1:0] post, input bit rd, input logic [AW-1:0] raddr);
    int idx;
    dif.debug_capture_enable = en;
    dif.debug_trigger_mask   = mask;
    dif.event_vec            = ev;
    dif.post_trigger_count   = post;
    dif.rd_en                = rd;
    dif.rd_addr              = raddr;
    // A read sees the RAM as it was before this cycle's write.
    if (rd) begin
      exp_q.push_back(m_mem[int'(raddr)]);
      known_q.push_back(m_known[int'(raddr)]);
    end
    if (!en) begin
      armed = 0;
    end else if (!armed) begin
      armed = 1; stored = 0; triggered = 0; done_m = 0; trig_no = 0;
    end else if (!done_m && ev != '0) begin
      idx = stored % DEPTH;
      m_mem[idx]   = {cyc, ev};
      m_known[idx] = 1;
      if (!triggered) begin
        if ((ev & mask) != '0) begin
          triggered = 1; trig_no = stored; trig_post = int'(post);
          if (post == '0) done_m = 1;
        end
      end else if (stored - trig_no == trig_post) begin
        done_m = 1;
      end
      stored++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (resetn && dif.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid: pulse with no read outstanding, rd_data=%0h", dif.rd_data);
      end else begin
        logic [W-1:0] e;
        bit k;
        e = exp_q.pop_front();
        k = known_q.pop_front();
        if (k) chk("rd_data", 64'(dif.rd_data), 64'(e));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [EW-1:0] mask;
    logic [AW-1:0] post;
    logic [EW-1:0] ev;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_known[i] = 0;
    end
    dif.debug_capture_enable = 0; dif.debug_trigger_mask = '0; dif.event_vec = '0;
    dif.post_trigger_count = '0; dif.rd_en = 0; dif.rd_addr = '0;
    sif.debug_capture_enable = 0; sif.debug_trigger_mask = '0; sif.event_vec = '0;
    sif.post_trigger_count = '0; sif.rd_en = 0; sif.rd_addr = '0;

    // Test 1: reset values, timestamp counting and wrap.
    repeat (3) @(posedge clk);
    #1;
    chk("reset rd_data", 64'(dif.rd_data), 64'd0);
    chk("reset rd_valid", 64'(dif.rd_valid), 64'd0);
    chk("reset ts", 64'(dif.debug_timestamp), 64'd0);
    @(negedge clk);
    resetn = 1;
    cyc = 0;
    check_status("reset");
    idle(10);
    chk("ts after 10", 64'(dif.debug_timestamp), 64'd10);
    idle(245);
    chk("small ts at max", 64'(sif.debug_timestamp), 64'hff);
    idle(1);
    chk("small ts wrapped", 64'(sif.debug_timestamp), 64'd0);

    // Test 3: mask 0, 300 stored events wrap the buffer.
    cycle(1, '0, 32'h1234, '0, 0, '0);
    for (int i = 0; i < 300; i++) begin
      ev = $urandom();
      if (ev == '0) ev = 32'h1;
      cycle(1, '0, ev, '0, 0, '0);
    end
    chk("t3 ptr", 64'(dif.debug_trace_ptr), 64'd44);
    chk("t3 wrapped", 64'(dif.trace_wrapped), 64'd1);
    chk("t3 state", 64'(dif.capture_state), 64'd1);
    check_status("t3");
    cycle(1, '0, '0, '0, 1, 8'd0);
    for (int i = 0; i < 8; i++) cycle(1, '0, '0, '0, 1, AW'($urandom_range(0, DEPTH - 1)));

    // Test 2: trigger at entry 3, post window 2.
    idle(1);
    cycle(1, 32'h1, '0, 8'd2, 0, '0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h1, 32'h2, 8'd2, 0, '0);
    cycle(1, 32'h1, 32'h1, 8'd2, 0, '0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h1, 32'h4, 8'd2, 0, '0);
    chk("t2 trig_idx", 64'(dif.trigger_index), 64'd3);
    chk("t2 ptr", 64'(dif.debug_trace_ptr), 64'd6);
    chk("t2 state", 64'(dif.capture_state), 64'd3);
    check_status("t2");
    for (int i = 0; i < 8; i++) cycle(1, 32'h1, '0, 8'd2, 1, AW'(i));

    // Test 4: post 0, DONE on the trigger write; re-arm clears ptr.
    idle(1);
    cycle(1, 32'h10, '0, 8'd0, 0, '0);
    cycle(1, 32'h10, 32'h30, 8'd0, 0, '0);
    chk("t4 ptr", 64'(dif.debug_trace_ptr), 64'd1);
    chk("t4 done", 64'(dif.capture_done), 64'd1);
    cycle(1, 32'h10, 32'h10, 8'd0, 0, '0);
    check_status("t4 hold");
    idle(1);
    chk("t4 idle", 64'(dif.capture_state), 64'd0);
    cycle(1, 32'h10, '0, 8'd0, 0, '0);
    chk("t4 rearm ptr", 64'(dif.debug_trace_ptr), 64'd0);
    check_status("t4 rearm");

    // Test 5: drop enable in POST with an event present.
    cycle(1, 32'h1, 32'h1, 8'd10, 0, '0);
    cycle(1, 32'h1, 32'h2, 8'd10, 0, '0);
    chk("t5 post", 64'(dif.capture_state), 64'd2);
    cycle(0, 32'h1, 32'h4, 8'd10, 0, '0);
    chk("t5 state", 64'(dif.capture_state), 64'd0);
    chk("t5 ptr", 64'(dif.debug_trace_ptr), 64'd2);
    check_status("t5");

    // Test 6: read the slot being written returns old data, reread returns new.
    cycle(1, '0, $urandom(), '0, 0, '0);
    cycle(1, '0, 32'h55, '0, 1, 8'd0);
    cycle(1, '0, '0, '0, 1, 8'd0);
    check_status("t6");

    // Random phase.
    mask = '0;
    post = '0;
    for (int i = 0; i < 700; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: mask = '0;
          1: mask = 32'h1 << $urandom_range(0, 31);
          default: mask = $urandom() & $urandom();
        endcase
        post = AW'($urandom_range(0, 20));
      end
      case ($urandom_range(0, 3))
        0, 1: ev = '0;
        2: ev = 32'h1 << $urandom_range(0, 31);
        default: ev = $urandom();
      endcase
      cycle($urandom_range(0, 24) != 0, mask, ev, post,
            $urandom_range(0, 2) == 0, AW'($urandom_range(0, DEPTH - 1)));
      check_status("rand");
    end

    idle(3);
    chk("reads drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
